flow_table_lookup: RTL and testbench
====================================

# flow_table_lookup

Sequential flow-table matcher placed directly downstream of the header parser. It captures each parsed OpenFlow header from `header_bus` when `headers_valid` rises. It then scans a small register-file flow table one entry per cycle and reports hit/miss plus the matching entry index to the action stage over a valid/ready handshake. The table is written by the host register interface; the block also keeps lookup, hit and drop statistics.

## Interface
- `NUM_ENTRIES`, default 8: number of table entries; a power of two, 2..32.
- `IDX_W`, default `log2(NUM_ENTRIES)`: entry index width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `header_bus` in `` `OF_HEADER_REG_WIDTH ``: parsed header fields.
- `headers_valid` in 1: header valid; stays high until end of packet.
- `tbl_wr_en` in 1: table write strobe.
- `tbl_wr_addr` in IDX_W: entry to write.
- `tbl_wr_key` in `` `OF_HEADER_REG_WIDTH ``: entry match key.
- `tbl_wr_mask` in `` `OF_HEADER_REG_WIDTH ``: care mask (1 = compare bit).
- `tbl_wr_valid` in 1: entry valid bit written with the key.
- `result_valid` out 1: lookup result available.
- `result_rdy` in 1: downstream accepts the result.
- `result_hit` out 1: 1 = match found.
- `result_index` out IDX_W: matching entry; 0 on miss.
- `lookup_cnt`, `hit_cnt`, `drop_cnt` out 32 each: statistics counters.

## Operation
- Clock `clk`; reset `reset`, synchronous, active-high.
- Reset state:
  - FSM goes to IDLE and all entry valid bits clear.
  - `result_valid`, `result_hit` and `result_index` clear to 0.
  - All counters clear to 0.
  - Keys and masks are not reset.
- Start detection: `hv_start = headers_valid & ~hv_q`, where `hv_q` is `headers_valid` registered (reset 0).
- IDLE:
  - On `hv_start`, register `header_bus` into `key_q`, set scan index `idx` to 0, go to SEARCH, and increment `lookup_cnt`.
- SEARCH, one entry compared per cycle:
  - Match condition: `valid[idx] & (((key_q ^ key[idx]) & mask[idx]) == 0)`.
  - On match: go to RESULT with `result_hit=1`, `result_index=idx`, and increment `hit_cnt`. The lowest-index match wins.
  - No match and `idx == NUM_ENTRIES-1`: go to RESULT with `result_hit=0`, `result_index=0`.
  - Otherwise: `idx <= idx+1`.
- RESULT:
  - `result_valid=1`; hit and index are held stable.
  - On a cycle with `result_rdy=1`, go to IDLE and clear `result_valid`.
- Drops: `hv_start` while in SEARCH or RESULT drops that header (no queueing) and increments `drop_cnt`.
- Table writes:
  - Accepted in any state and take effect on the next edge.
  - The compare in the same cycle uses the pre-write contents.
  - Writing an entry with `tbl_wr_valid=0` disables it.
- Counters are 32-bit and wrap modulo 2^32 without saturating.
- `reset` asserted mid-search or mid-result abandons the lookup. `result_valid` reads 0 on the next cycle.

## Timing
- `hv_start` is sampled at edge E0 (capture).
- A hit on entry k gives `result_valid=1` after edge E(k+1). The latency is k+2 cycles from the first cycle `headers_valid` is high.
- A miss gives `result_valid=1` after edge E(NUM_ENTRIES).
- With `result_rdy` held high, RESULT lasts exactly one cycle and IDLE is re-entered after the next edge.
- Back-to-back lookups:
  - A new `hv_start` is accepted no sooner than the cycle after RESULT is left.
  - A header arriving in the cycle RESULT is exited (state still RESULT) is dropped.
- `result_hit` and `result_index` are valid only while `result_valid=1`. Otherwise they hold their last value.

## Configuration
- Macro `FLOW_TABLE_WILDCARD_EN`.
- Defined: per-entry mask storage is instantiated and the masked compare above is used.
- Undefined:
  - No mask storage; `tbl_wr_mask` is ignored.
  - The compare is exact, `valid[idx] & (key_q == key[idx])`.
  - All other behaviour and timing are identical.

## Structure
- Shared package/defines file holds:
  - `` `OF_HEADER_REG_WIDTH `` and field position/width macros (already shared with the parser).
  - FSM state encodings IDLE=0, SEARCH=1, RESULT=2.
  - The counter width constant (32).
- One sub-module, `flow_entry_match`: combinational compare of `key_q` against one entry (key, mask, valid), with the mask path under `FLOW_TABLE_WILDCARD_EN`. It is instantiated once and fed the mux-selected entry `idx`.

## Test plan
- Exact hit:
  - Setup: write entry 3 with key = header H, mask all-ones, valid=1; entries 0–2 invalid.
  - Stimulus: drive H with a `headers_valid` pulse.
  - Expected: `result_valid` after 4 edges, `hit=1`, `index=3`; `lookup_cnt=1`, `hit_cnt=1`.
- Miss:
  - Setup: empty table (after reset).
  - Stimulus: any header.
  - Expected: `result_valid` after 8 edges (NUM_ENTRIES=8), `hit=0`, `index=0`; `hit_cnt=0`.
- Priority and wildcard (`FLOW_TABLE_WILDCARD_EN` defined):
  - Setup: entry 1 mask covers only the `OF_DL_TYPE` field, key 0x0800; entry 2 is an exact match of the same IP header.
  - Expected: `index=1`.
  - Rebuild with the macro undefined: `index=2`.
- Drop while busy:
  - Stimulus: a second `headers_valid` rising edge during SEARCH, with `result_rdy` held 0 for 5 cycles.
  - Expected: `drop_cnt=1`, a single result, `result_valid` held stable 5 cycles, cleared the cycle after `result_rdy=1`.
- Write during search:
  - Stimulus: rewrite entry 5 to invalid in the cycle `idx=5` is compared.
  - Expected: that lookup still hits 5; a repeat lookup misses.
- Reset mid-search:
  - Stimulus: assert `reset` while `idx=2`.
  - Expected: `result_valid=0`, counters 0, all entries invalid; the next lookup misses.

Source files
------------

// File: rtl/flow_table_lookup_pkg.sv
// Shared OpenFlow header layout macros and lookup-engine types.
// Optional build macro FLOW_TABLE_WILDCARD_EN enables per-entry care masks.
`ifndef OF_HEADER_DEFS
`define OF_HEADER_DEFS
`define OF_HEADER_REG_WIDTH 224
`define OF_TP_DST_POS       0
`define OF_TP_DST_WIDTH     16
`define OF_TP_SRC_POS       16
`define OF_TP_SRC_WIDTH     16
`define OF_NW_DST_POS       32
`define OF_NW_DST_WIDTH     32
`define OF_NW_SRC_POS       64
`define OF_NW_SRC_WIDTH     32
`define OF_NW_PROTO_POS     96
`define OF_NW_PROTO_WIDTH   8
`define OF_DL_TYPE_POS      104
`define OF_DL_TYPE_WIDTH    16
`define OF_DL_DST_POS       120
`define OF_DL_DST_WIDTH     48
`define OF_DL_SRC_POS       168
`define OF_DL_SRC_WIDTH     48
`define OF_IN_PORT_POS      216
`define OF_IN_PORT_WIDTH    8
`endif

package flow_table_lookup_pkg;
    localparam int HDR_W = `OF_HEADER_REG_WIDTH;
    localparam int CNT_W = 32;

    typedef logic [HDR_W-1:0] hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RESULT = 2'd2
    } lookup_state_e;
endpackage

// File: rtl/flow_table_lookup_if.sv
// Header input, host table-write port, result handshake and statistics bundle.
interface flow_table_lookup_if #(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
);
    import flow_table_lookup_pkg::*;

    hdr_t             header_bus;
    logic             headers_valid;
    logic             tbl_wr_en;
    logic [IDX_W-1:0] tbl_wr_addr;
    hdr_t             tbl_wr_key;
    hdr_t             tbl_wr_mask;
    logic             tbl_wr_valid;
    logic             result_valid;
    logic             result_rdy;
    logic             result_hit;
    logic [IDX_W-1:0] result_index;
    logic [CNT_W-1:0] lookup_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport slave (
        input  header_bus, headers_valid,
        input  tbl_wr_en, tbl_wr_addr, tbl_wr_key, tbl_wr_mask, tbl_wr_valid,
        input  result_rdy,
        output result_valid, result_hit, result_index,
        output lookup_cnt, hit_cnt, drop_cnt
    );

    modport master (
        output header_bus, headers_valid,
        output tbl_wr_en, tbl_wr_addr, tbl_wr_key, tbl_wr_mask, tbl_wr_valid,
        output result_rdy,
        input  result_valid, result_hit, result_index,
        input  lookup_cnt, hit_cnt, drop_cnt
    );
endinterface

// File: rtl/flow_table_lookup_match.sv
// flow_entry_match: combinational compare of the captured key against one entry.
// FLOW_TABLE_WILDCARD_EN adds the care-mask input; otherwise the compare is exact.
module flow_entry_match
    import flow_table_lookup_pkg::*;
(
    input  hdr_t key_i,
    input  hdr_t entry_key_i,
`ifdef FLOW_TABLE_WILDCARD_EN
    input  hdr_t entry_mask_i,
`endif
    input  logic entry_valid_i,
    output logic match_o
);
`ifdef FLOW_TABLE_WILDCARD_EN
    assign match_o = entry_valid_i & (((key_i ^ entry_key_i) & entry_mask_i) == '0);
`else
    assign match_o = entry_valid_i & (key_i == entry_key_i);
`endif
endmodule

// File: rtl/flow_table_lookup.sv
// Sequential flow-table matcher: scans one entry per cycle, lowest index wins.
// FLOW_TABLE_WILDCARD_EN selects masked (wildcard) entries instead of exact match.
module flow_table_lookup
    import flow_table_lookup_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic clk,
    input  logic reset,
    flow_table_lookup_if.slave bus
);
    lookup_state_e    state_q, state_d;
    hdr_t             key_q, key_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hv_q;
    logic             hv_start;
    logic             result_hit_q, result_hit_d;
    logic [IDX_W-1:0] result_index_q, result_index_d;
    logic [CNT_W-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             entry_match;

    hdr_t key_mem_q   [NUM_ENTRIES];
    logic valid_mem_q [NUM_ENTRIES];
`ifdef FLOW_TABLE_WILDCARD_EN
    hdr_t mask_mem_q  [NUM_ENTRIES];
`else
    logic unused_mask;
    assign unused_mask = ^bus.tbl_wr_mask;
`endif

    // Table registers: writes land on the next edge, so a same-cycle compare sees old contents.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            logic wr_sel;
            assign wr_sel = bus.tbl_wr_en && (bus.tbl_wr_addr == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_mem_q[gi] <= 1'b0;
                end else if (wr_sel) begin
                    valid_mem_q[gi] <= bus.tbl_wr_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (wr_sel) begin
                    key_mem_q[gi] <= bus.tbl_wr_key;
`ifdef FLOW_TABLE_WILDCARD_EN
                    mask_mem_q[gi] <= bus.tbl_wr_mask;
`endif
                end
            end
        end
    endgenerate

    flow_entry_match u_match (
        .key_i         (key_q),
        .entry_key_i   (key_mem_q[idx_q]),
`ifdef FLOW_TABLE_WILDCARD_EN
        .entry_mask_i  (mask_mem_q[idx_q]),
`endif
        .entry_valid_i (valid_mem_q[idx_q]),
        .match_o       (entry_match)
    );

    assign hv_start = bus.headers_valid & ~hv_q;

    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        idx_d          = idx_q;
        result_hit_d   = result_hit_q;
        result_index_d = result_index_q;
        lookup_cnt_d   = lookup_cnt_q;
        hit_cnt_d      = hit_cnt_q;
        drop_cnt_d     = drop_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (hv_start) begin
                    key_d        = bus.header_bus;
                    idx_d        = '0;
                    state_d      = ST_SEARCH;
                    lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
                end
            end
            ST_SEARCH: begin
                if (entry_match) begin
                    state_d        = ST_RESULT;
                    result_hit_d   = 1'b1;
                    result_index_d = idx_q;
                    hit_cnt_d      = hit_cnt_q + CNT_W'(1);
                end else if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_d        = ST_RESULT;
                    result_hit_d   = 1'b0;
                    result_index_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_RESULT: begin
                if (bus.result_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // No queueing: a header starting while busy (including the RESULT exit cycle) is lost.
        if (hv_start && (state_q != ST_IDLE)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            hv_q           <= 1'b0;
            result_hit_q   <= 1'b0;
            result_index_q <= '0;
            lookup_cnt_q   <= '0;
            hit_cnt_q      <= '0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            hv_q           <= bus.headers_valid;
            result_hit_q   <= result_hit_d;
            result_index_q <= result_index_d;
            lookup_cnt_q   <= lookup_cnt_d;
            hit_cnt_q      <= hit_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        key_q <= key_d;
    end

    assign bus.result_valid = (state_q == ST_RESULT);
    assign bus.result_hit   = result_hit_q;
    assign bus.result_index = result_index_q;
    assign bus.lookup_cnt   = lookup_cnt_q;
    assign bus.hit_cnt      = hit_cnt_q;
    assign bus.drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_flow_table_lookup.sv
// Directed scoreboard bench for flow_table_lookup (NUM_ENTRIES = 8).
module tb_flow_table_lookup;
    import flow_table_lookup_pkg::*;

    localparam int N  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic          hit;
        logic [IW-1:0] idx;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   exp_lookup;
    int   exp_hit;
    int   exp_drop;
    exp_t sb_q[$];

    flow_table_lookup_if #(.NUM_ENTRIES(N), .IDX_W(IW)) bus ();

    flow_table_lookup #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic hdr_t mk_hdr(input logic [15:0] dl_type, input logic [31:0] nw_src,
                                    input logic [15:0] tp_dst);
        hdr_t h;
        h = '0;
        h[`OF_IN_PORT_POS +: 8]  = 8'h01;
        h[`OF_DL_TYPE_POS +: 16] = dl_type;
        h[`OF_NW_SRC_POS +: 32]  = nw_src;
        h[`OF_TP_DST_POS +: 16]  = tp_dst;
        return h;
    endfunction

    // Monitor: every accepted result is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.result_valid && bus.result_rdy) begin
                $display("result hit=%0d index=%0d", bus.result_hit, bus.result_index);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got hit=%0d index=%0d expected none",
                             bus.result_hit, bus.result_index);
                end else begin
                    e = sb_q.pop_front();
                    check("result_hit", 32'(bus.result_hit), 32'(e.hit));
                    check("result_index", 32'(bus.result_index), 32'(e.idx));
                end
            end
        end
    end

    task automatic check_counters(input string tag);
        check({tag, "_lookup_cnt"}, bus.lookup_cnt, 32'(exp_lookup));
        check({tag, "_hit_cnt"}, bus.hit_cnt, 32'(exp_hit));
        check({tag, "_drop_cnt"}, bus.drop_cnt, 32'(exp_drop));
    endtask

    task automatic tbl_write(input int addr, input hdr_t k, input hdr_t m, input logic v);
        @(posedge clk); #1;
        bus.tbl_wr_en    = 1'b1;
        bus.tbl_wr_addr  = IW'(addr);
        bus.tbl_wr_key   = k;
        bus.tbl_wr_mask  = m;
        bus.tbl_wr_valid = v;
        $display("write entry=%0d valid=%0d", addr, v);
        @(posedge clk); #1;
        bus.tbl_wr_en = 1'b0;
    endtask

    // One lookup with result_rdy high; elat counts edges after the capture edge.
    // wr_edge > 0 invalidates entry 5 during the cycle following that edge.
    task automatic lookup(input string name, input hdr_t h, input logic eh, input int ei,
                          input int elat, input int wr_edge);
        int n;
        exp_t e;
        e.hit = eh;
        e.idx = IW'(ei);
        sb_q.push_back(e);
        exp_lookup++;
        if (eh) exp_hit++;
        @(posedge clk); #1;
        bus.header_bus    = h;
        bus.headers_valid = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == wr_edge) begin
                bus.tbl_wr_en    = 1'b1;
                bus.tbl_wr_addr  = IW'(5);
                bus.tbl_wr_valid = 1'b0;
            end else begin
                bus.tbl_wr_en = 1'b0;
            end
            if (bus.result_valid) break;
        end
        bus.tbl_wr_en = 1'b0;
        $display("lookup %s latency=%0d", name, n);
        check({name, "_latency"}, 32'(n), 32'(elat));
        @(posedge clk); #1;
        check({name, "_valid_cleared"}, 32'(bus.result_valid), 32'd0);
        bus.headers_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        hdr_t h_a, h_ip, h_m, h_5, h_7, ones, dl_mask, dl_key;
        int   held;
        int   n;

        n_checks = 0;
        n_pass = 0;
        exp_lookup = 0;
        exp_hit = 0;
        exp_drop = 0;
        h_a  = mk_hdr(16'h86dd, 32'h0a000001, 16'd80);
        h_ip = mk_hdr(16'h0800, 32'hc0a80101, 16'd443);
        h_m  = mk_hdr(16'h88cc, 32'h01020304, 16'd7);
        h_5  = mk_hdr(16'h0806, 32'h00000005, 16'd5);
        h_7  = mk_hdr(16'h8100, 32'h00000007, 16'd7);
        ones = '1;
        dl_mask = '0;
        dl_mask[`OF_DL_TYPE_POS +: 16] = 16'hffff;
        dl_key = '0;
        dl_key[`OF_DL_TYPE_POS +: 16] = 16'h0800;

        reset = 1'b1;
        bus.header_bus = '0;
        bus.headers_valid = 1'b0;
        bus.tbl_wr_en = 1'b0;
        bus.tbl_wr_addr = '0;
        bus.tbl_wr_key = '0;
        bus.tbl_wr_mask = '0;
        bus.tbl_wr_valid = 1'b0;
        bus.result_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_result_valid", 32'(bus.result_valid), 32'd0);
        check_counters("reset");

        lookup("miss_empty", h_m, 1'b0, 0, 8, 0);
        check_counters("miss");

        tbl_write(3, h_a, ones, 1'b1);
        lookup("exact_hit3", h_a, 1'b1, 3, 4, 0);
        check_counters("hit3");

        tbl_write(1, dl_key, dl_mask, 1'b1);
        tbl_write(2, h_ip, ones, 1'b1);
`ifdef FLOW_TABLE_WILDCARD_EN
        lookup("wildcard_prio", h_ip, 1'b1, 1, 2, 0);
`else
        lookup("exact_prio", h_ip, 1'b1, 2, 3, 0);
`endif
        check_counters("prio");

        // Second header starts while searching; result held with result_rdy low.
        sb_q.push_back('{hit: 1'b0, idx: '0});
        exp_lookup++;
        exp_drop++;
        @(posedge clk); #1;
        bus.result_rdy = 1'b0;
        bus.header_bus = h_m;
        bus.headers_valid = 1'b1;
        @(posedge clk); #1;
        bus.headers_valid = 1'b0;
        @(posedge clk); #1;
        bus.header_bus = h_ip;
        bus.headers_valid = 1'b1;
        n = 1;
        while (n < 40 && !bus.result_valid) begin
            @(posedge clk); #1;
            n++;
        end
        $display("lookup drop_busy latency=%0d", n);
        check("drop_latency", 32'(n), 32'd8);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.result_valid && !bus.result_hit && bus.result_index == '0) held++;
        end
        check("drop_result_held", 32'(held), 32'd5);
        bus.result_rdy = 1'b1;
        @(posedge clk); #1;
        check("drop_valid_cleared", 32'(bus.result_valid), 32'd0);
        bus.headers_valid = 1'b0;
        @(posedge clk); #1;
        check_counters("drop");

        tbl_write(5, h_5, ones, 1'b1);
        lookup("write_during_search", h_5, 1'b1, 5, 6, 5);
        lookup("after_invalidate", h_5, 1'b0, 0, 8, 0);
        tbl_write(7, h_7, ones, 1'b1);
        lookup("last_entry_hit", h_7, 1'b1, 7, 8, 0);
        check_counters("last");

        // Reset while the scan sits on entry 2.
        @(posedge clk); #1;
        bus.header_bus = h_a;
        bus.headers_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        bus.headers_valid = 1'b0;
        exp_lookup = 0;
        exp_hit = 0;
        exp_drop = 0;
        check("midreset_result_valid", 32'(bus.result_valid), 32'd0);
        check_counters("midreset");
        @(posedge clk); #1 reset = 1'b0;
        lookup("post_reset_miss", h_a, 1'b0, 0, 8, 0);
        check_counters("post_reset");

        repeat (2) @(posedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
